frame_sync_inserter: RTL and testbench



---
 rtl/frame_sync_inserter_if.sv | 12 +
 rtl/frame_sync_inserter.sv | 119 +++++++++++
 tb/tb_frame_sync_inserter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sync_inserter_if.sv
// Upstream payload stream into the frame sync inserter.
// A bit transfers on a rising clock edge where data_valid and data_in_ready
// are both high; data_in_ready never depends on data_valid, and the source
// holds data_valid/data_in until that edge.
interface frame_sync_inserter_if;
  logic data_in;
  logic data_valid;
  logic data_in_ready;

  modport master (output data_in, output data_valid, input data_in_ready);
  modport slave  (input data_in, input data_valid, output data_in_ready);
endinterface

// File: rtl/frame_sync_inserter.sv
// Serial framer: emits SYNC_WORD (MSB first) and then PAYLOAD_LEN bits taken
// from the upstream stream, repeating for as long as payload is offered.
module frame_sync_inserter #(
  parameter int                    SYNC_LEN    = 8,
  parameter logic [SYNC_LEN-1:0]   SYNC_WORD   = 8'b10110001,
  parameter int                    PAYLOAD_LEN = 56,
  parameter int                    FRAME_CNT_W = 16
) (
  input  logic                   clk_out,
  input  logic                   rst,
  frame_sync_inserter_if.slave   up,
  output logic                   data_out,
  output logic                   out_valid,
  output logic                   frame_start,
  output logic                   underrun,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [1:0]             fsm_state
);

  localparam int MAX_LEN = (SYNC_LEN > PAYLOAD_LEN) ? SYNC_LEN : PAYLOAD_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;
  localparam int IDX_W   = $clog2(SYNC_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   data_out_n, out_valid_n, frame_start_n, underrun_n;
  logic [FRAME_CNT_W-1:0] frame_cnt_n;
  logic [IDX_W-1:0]       sync_idx;

  // In SYNC, cnt counts sync bits already sent, so the next one is at SYNC_LEN-1-cnt.
  assign sync_idx         = IDX_W'(CNT_W'(SYNC_LEN - 1) - cnt);
  assign up.data_in_ready = (state == PAYLOAD);
  assign fsm_state        = state;

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      data_out    <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      data_out    <= data_out_n;
      out_valid   <= out_valid_n;
      frame_start <= frame_start_n;
      underrun    <= underrun_n;
      frame_cnt   <= frame_cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    data_out_n    = data_out;
    out_valid_n   = out_valid;
    frame_start_n = 1'b0;
    underrun_n    = underrun;
    frame_cnt_n   = frame_cnt;
    case (state)
      IDLE: begin
        if (up.data_valid) begin
          // The sync MSB leaves on the same edge that commits to the frame.
          data_out_n    = SYNC_WORD[SYNC_LEN-1];
          out_valid_n   = 1'b1;
          frame_start_n = 1'b1;
          cnt_n         = CNT_W'(1);
          state_n       = SYNC;
        end else begin
          data_out_n  = 1'b0;
          out_valid_n = 1'b0;
        end
      end
      SYNC: begin
        data_out_n  = SYNC_WORD[sync_idx];
        out_valid_n = 1'b1;
        if (cnt == CNT_W'(SYNC_LEN - 1)) begin
          cnt_n   = '0;
          state_n = PAYLOAD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PAYLOAD: begin
        if (up.data_valid) begin
          data_out_n  = up.data_in;
          out_valid_n = 1'b1;
          if (cnt == CNT_W'(PAYLOAD_LEN - 1)) begin
            frame_cnt_n = frame_cnt + FRAME_CNT_W'(1);
            cnt_n       = '0;
            state_n     = IDLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else begin
          data_out_n  = 1'b0;
          out_valid_n = 1'b0;
          underrun_n  = 1'b1;
        end
      end
      default: begin
        state_n     = IDLE;
        cnt_n       = '0;
        data_out_n  = 1'b0;
        out_valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_sync_inserter.sv
// Directed bench for frame_sync_inserter: default instance plus a 4-bit
// frame counter instance fed the same upstream stream.
module tb_frame_sync_inserter;

  logic        clk_out;
  logic        rst;
  logic        data_out, out_valid, frame_start, underrun;
  logic [15:0] frame_cnt;
  logic [1:0]  fsm_state;
  logic        w_data_out, w_out_valid, w_frame_start, w_underrun;
  logic [3:0]  w_frame_cnt;
  logic [1:0]  w_fsm_state;

  int tests;
  int fails;
  int exp_cnt;
  logic [7:0] sw;

  frame_sync_inserter_if u_if ();
  frame_sync_inserter_if u_if_w ();

  assign u_if_w.data_valid = u_if.data_valid;
  assign u_if_w.data_in    = u_if.data_in;

  frame_sync_inserter dut (
    .clk_out     (clk_out),
    .rst         (rst),
    .up          (u_if),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .frame_start (frame_start),
    .underrun    (underrun),
    .frame_cnt   (frame_cnt),
    .fsm_state   (fsm_state)
  );

  frame_sync_inserter #(.FRAME_CNT_W(4)) dut_w (
    .clk_out     (clk_out),
    .rst         (rst),
    .up          (u_if_w),
    .data_out    (w_data_out),
    .out_valid   (w_out_valid),
    .frame_start (w_frame_start),
    .underrun    (w_underrun),
    .frame_cnt   (w_frame_cnt),
    .fsm_state   (w_fsm_state)
  );

  // clock / reset
  initial begin
    clk_out = 1'b0;
    forever #5 clk_out = ~clk_out;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // driver: present inputs, take one edge, settle 1 time unit past it
  task automatic drive_cycle(input logic v, input logic d);
    u_if.data_valid = v;
    u_if.data_in    = d;
    @(posedge clk_out);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b1, 1'b0);
    exp_cnt = 0;
    tests++; if (data_out !== 1'b0) begin fails++; $display("FAIL reset_data_out got %b want 0", data_out); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (u_if.data_in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", u_if.data_in_ready); end
    tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b want 0", underrun); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    tests++; if (fsm_state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", fsm_state); end
    tests++; if (w_frame_cnt !== 4'd0) begin fails++; $display("FAIL reset_wrap_cnt got %0d want 0", w_frame_cnt); end
    rst = 1'b1;
    drive_cycle(1'b0, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_single_frame;
    logic [55:0] pl;
    int rdy;
    for (int k = 0; k < 56; k++) pl[k] = (k % 2 == 0);
    rdy = 0;
    for (int i = 0; i < 64; i++) begin
      logic d, e;
      d = (i >= 8) ? pl[i-8] : 1'($urandom_range(0, 1));
      drive_cycle(1'b1, d);
      e = (i < 8) ? sw[7-i] : pl[i-8];
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid cyc %0d got %b want 1", i, out_valid); end
      tests++; if (data_out !== e) begin fails++; $display("FAIL single_data cyc %0d got %b want %b", i, data_out, e); end
      tests++; if (frame_start !== (i == 0)) begin fails++; $display("FAIL single_frame_start cyc %0d got %b want %b", i, frame_start, (i == 0)); end
      if (u_if.data_in_ready === 1'b1) rdy++;
    end
    exp_cnt++;
    tests++; if (rdy != 56) begin fails++; $display("FAIL single_ready_cycles got %0d want 56", rdy); end
    tests++; if (frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL single_frame_cnt got %0d want %0d", frame_cnt, exp_cnt); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL single_underrun got %b want 0", underrun); end
    drive_cycle(1'b0, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_tail_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [55:0] pls [3];
    for (int f = 0; f < 3; f++) pls[f] = {24'($urandom), 32'($urandom)};
    for (int i = 0; i < 192; i++) begin
      int f, j;
      logic d, e;
      f = i / 64;
      j = i % 64;
      d = (j >= 8) ? pls[f][j-8] : 1'($urandom_range(0, 1));
      drive_cycle(1'b1, d);
      e = (j < 8) ? sw[7-j] : pls[f][j-8];
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_out_valid cyc %0d got %b want 1", i, out_valid); end
      tests++; if (data_out !== e) begin fails++; $display("FAIL b2b_data cyc %0d got %b want %b", i, data_out, e); end
      tests++; if (frame_start !== (j == 0)) begin fails++; $display("FAIL b2b_frame_start cyc %0d got %b want %b", i, frame_start, (j == 0)); end
    end
    exp_cnt += 3;
    tests++; if (frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL b2b_frame_cnt got %0d want %0d", frame_cnt, exp_cnt); end
    drive_cycle(1'b0, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_tail_valid got %b want 0", out_valid); end
  endtask

  task automatic test_stall;
    logic [55:0] pl;
    pl = {24'($urandom), 32'($urandom)};
    for (int i = 0; i < 64; i++) begin
      logic d, e;
      if (i == 18) begin
        for (int s = 0; s < 3; s++) begin
          drive_cycle(1'b0, 1'($urandom_range(0, 1)));
          tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_out_valid s %0d got %b want 0", s, out_valid); end
          tests++; if (data_out !== 1'b0) begin fails++; $display("FAIL stall_data s %0d got %b want 0", s, data_out); end
          tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL stall_underrun s %0d got %b want 1", s, underrun); end
          tests++; if (u_if.data_in_ready !== 1'b1) begin fails++; $display("FAIL stall_ready s %0d got %b want 1", s, u_if.data_in_ready); end
        end
      end
      d = (i >= 8) ? pl[i-8] : 1'($urandom_range(0, 1));
      drive_cycle(1'b1, d);
      e = (i < 8) ? sw[7-i] : pl[i-8];
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_frame_valid cyc %0d got %b want 1", i, out_valid); end
      tests++; if (data_out !== e) begin fails++; $display("FAIL stall_frame_data cyc %0d got %b want %b", i, data_out, e); end
      if (i == 17) begin
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL stall_pre_underrun got %b want 0", underrun); end
      end
      if (i == 62) begin
        tests++; if (frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL stall_cnt_early got %0d want %0d", frame_cnt, exp_cnt); end
      end
    end
    exp_cnt++;
    tests++; if (frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL stall_frame_cnt got %0d want %0d", frame_cnt, exp_cnt); end
    tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL stall_sticky got %b want 1", underrun); end
  endtask

  task automatic test_reset_mid;
    logic [55:0] pl;
    pl = {24'($urandom), 32'($urandom)};
    for (int i = 0; i < 28; i++) begin
      logic d, e;
      d = (i >= 8) ? pl[i-8] : 1'($urandom_range(0, 1));
      drive_cycle(1'b1, d);
      e = (i < 8) ? sw[7-i] : pl[i-8];
      tests++; if (data_out !== e) begin fails++; $display("FAIL rmid_pre_data cyc %0d got %b want %b", i, data_out, e); end
    end
    rst = 1'b0;
    drive_cycle(1'b1, 1'b1);
    exp_cnt = 0;
    tests++; if (data_out !== 1'b0) begin fails++; $display("FAIL rmid_data_out got %b want 0", data_out); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    tests++; if (u_if.data_in_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready got %b want 0", u_if.data_in_ready); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL rmid_underrun got %b want 0", underrun); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL rmid_frame_cnt got %0d want 0", frame_cnt); end
    rst = 1'b1;
    pl = {24'($urandom), 32'($urandom)};
    for (int i = 0; i < 64; i++) begin
      logic d, e;
      d = (i >= 8) ? pl[i-8] : 1'($urandom_range(0, 1));
      drive_cycle(1'b1, d);
      e = (i < 8) ? sw[7-i] : pl[i-8];
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rmid_out_valid cyc %0d got %b want 1", i, out_valid); end
      tests++; if (data_out !== e) begin fails++; $display("FAIL rmid_data cyc %0d got %b want %b", i, data_out, e); end
      tests++; if (frame_start !== (i == 0)) begin fails++; $display("FAIL rmid_frame_start cyc %0d got %b want %b", i, frame_start, (i == 0)); end
    end
    exp_cnt++;
    tests++; if (frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL rmid_post_cnt got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_sync_input;
    logic [55:0] pl;
    pl = {24'($urandom), 32'($urandom)};
    for (int i = 0; i < 64; i++) begin
      logic v, d, e;
      v = (i == 0 || i >= 8) ? 1'b1 : 1'(i % 2);
      d = (i >= 8) ? pl[i-8] : 1'($urandom_range(0, 1));
      drive_cycle(v, d);
      e = (i < 8) ? sw[7-i] : pl[i-8];
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL syncin_out_valid cyc %0d got %b want 1", i, out_valid); end
      tests++; if (data_out !== e) begin fails++; $display("FAIL syncin_data cyc %0d got %b want %b", i, data_out, e); end
      if (i < 8) begin
        tests++;
        if (u_if.data_in_ready !== (i == 7)) begin
          fails++; $display("FAIL syncin_ready cyc %0d got %b want %b", i, u_if.data_in_ready, (i == 7));
        end
      end
    end
    exp_cnt++;
    tests++; if (frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL syncin_frame_cnt got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_wrap;
    int bad_valid;
    rst = 1'b0;
    drive_cycle(1'b0, 1'b0);
    rst = 1'b1;
    exp_cnt = 0;
    bad_valid = 0;
    for (int f = 0; f < 17; f++) begin
      for (int j = 0; j < 64; j++) begin
        drive_cycle(1'b1, 1'($urandom_range(0, 1)));
        if (out_valid !== 1'b1 || w_out_valid !== 1'b1) bad_valid++;
      end
      exp_cnt++;
      if (f == 15) begin
        tests++; if (frame_cnt !== 16'd16) begin fails++; $display("FAIL wrap_main_16 got %0d want 16", frame_cnt); end
        tests++; if (w_frame_cnt !== 4'd0) begin fails++; $display("FAIL wrap_small_16 got %0d want 0", w_frame_cnt); end
      end
    end
    tests++; if (bad_valid != 0) begin fails++; $display("FAIL wrap_valid_gaps got %0d want 0", bad_valid); end
    tests++; if (frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL wrap_main_17 got %0d want %0d", frame_cnt, exp_cnt); end
    tests++; if (w_frame_cnt !== 4'd1) begin fails++; $display("FAIL wrap_small_17 got %0d want 1", w_frame_cnt); end
    tests++; if (w_underrun !== 1'b0) begin fails++; $display("FAIL wrap_underrun got %b want 0", w_underrun); end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    exp_cnt = 0;
    sw      = 8'b10110001;
    rst     = 1'b0;
    u_if.data_valid = 1'b0;
    u_if.data_in    = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_sync_input();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
